opl3_timers: RTL and testbench
==============================

Name: opl3_timers

Overview:
- Implements the two OPL3 programmable interval timers (Timer 1 and Timer 2) plus their status/IRQ flags.
- Sits directly downstream of the clock-enable divider. It consumes the single-cycle 80 us tick pulse (12.5 kHz) that the divider produces on the system clock.
- Timer 1 advances once per tick. Timer 2 advances once per TIMER2_DIV ticks (320 us).
- Preset, start and mask controls come from the register file. Flags drive the status register and the host IRQ.

Parameters:
- TIMER2_DIV, 4: number of input ticks per Timer 2 increment; integer >= 1.
- CNT_WIDTH, 8: width of both timer counters and presets.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick_en  in  1  single-cycle 80 us clock-enable pulse from the divider
- timer1_preset  in  CNT_WIDTH  Timer 1 reload value
- timer2_preset  in  CNT_WIDTH  Timer 2 reload value
- st1  in  1  Timer 1 start (level)
- st2  in  1  Timer 2 start (level)
- mt1  in  1  Timer 1 flag mask (level)
- mt2  in  1  Timer 2 flag mask (level)
- irq_rst  in  1  single-cycle pulse; clears both flags
- ft1  out  1  Timer 1 overflow flag
- ft2  out  1  Timer 2 overflow flag
- irq  out  1  ft1 OR ft2, registered
- status  out  8  {irq, ft1, ft2, 5'b0}

Behaviour:
- Reset (asynchronous, active-high) forces the following to 0, with all outputs 0:
  - cnt1, cnt2
  - prescaler
  - st1_q, st2_q (start-edge registers)
  - ft1, ft2, irq
- All state updates on posedge clk. Outputs are registered, so each change is visible the cycle after its cause.
- Prescaler:
  - free-running 0..TIMER2_DIV-1 counter, advancing on each tick_en; never cleared by st2.
  - tick2 = tick_en AND (prescaler == TIMER2_DIV-1). It wraps to 0 on that same tick.
- Per-timer run state (n = 1, 2):
  - LOAD: st_n rises (st_n=1, st_n_q=0) -> cnt_n <= preset_n. LOAD has priority over a coincident tick; that tick is not counted.
  - RUN: st_n=1 and tick_n (tick_en for Timer 1, tick2 for Timer 2):
    - cnt_n != max -> cnt_n <= cnt_n+1.
    - cnt_n == max (all ones) -> overflow: cnt_n <= preset_n (current input value), and ft_n set unless mt_n=1.
  - STOP: st_n=0 -> cnt_n holds its value; no overflow possible.
  - A later rising edge of st_n reloads the preset.
- Overflow period: (2^CNT_WIDTH - preset) ticks from LOAD. Preset 0xFF gives an overflow every tick.
- Flag rules, in priority order per cycle:
  1. mt_n=1 -> ft_n <= 0. The mask clears a flag that is already set.
  2. Overflow with mt_n=0 -> ft_n <= 1. Set wins over a coincident irq_rst, so no event is lost.
  3. irq_rst=1 -> ft_n <= 0.
  4. Otherwise ft_n holds.
- irq <= next-state ft1 OR next-state ft2, so irq changes on the same edge as the flags.
- Mask and stop do not stop counting interaction: a masked timer keeps counting and reloading while st_n=1; only its flag is suppressed.
- Preset changes while running take effect only at the next overflow reload or the next LOAD.
- tick_en asserted for multiple consecutive cycles is treated as multiple ticks; no edge detection is applied to tick_en.

Test Plan:
- Reset mid-run: assert reset while cnt1=0x80 and ft1=1 -> cnt1, ft1, irq and status go 0 immediately, without waiting for clk.
- timer1_preset=0xFE, st1 rises, ticks every 3 clk:
  - tick 1 -> cnt1=0xFF; tick 2 -> cnt1=0xFE, ft1=1, irq=1, status=0xC0.
  - irq_rst pulse -> ft1=0, irq=0.
- timer2_preset=0xFF, st2=1, TIMER2_DIV=4: ft2 sets after 4 tick_en pulses measured from the prescaler wrap, status=0xA0. With mt2=1 and 8 more ticks, ft2 stays 0 and cnt2 keeps reloading to 0xFF.
- Coincident events: overflow of Timer 1 on the same cycle as irq_rst -> ft1=1 afterwards. mt1 asserted while ft1=1 -> ft1=0 next cycle.
- Start/stop: preset 0x10, run 5 ticks (cnt1=0x15), drop st1, apply 10 ticks -> cnt1 stays 0x15. Raise st1 coincident with tick_en -> cnt1=0x10, that tick is not counted.
- Both timers overflow on the same cycle with masks clear -> ft1=ft2=1, status=0xE0. One irq_rst pulse -> status=0x00.

Source files
------------

// File: rtl/opl3_timers_if.sv
// Control/status bundle between the OPL3 register file and the interval timers.
interface opl3_timers_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 tick_en;
    logic [CNT_WIDTH-1:0] timer1_preset;
    logic [CNT_WIDTH-1:0] timer2_preset;
    logic                 st1;
    logic                 st2;
    logic                 mt1;
    logic                 mt2;
    logic                 irq_rst;
    logic                 ft1;
    logic                 ft2;
    logic                 irq;
    logic [7:0]           status;

    modport master (
        output tick_en, timer1_preset, timer2_preset, st1, st2, mt1, mt2, irq_rst,
        input  ft1, ft2, irq, status
    );

    modport slave (
        input  tick_en, timer1_preset, timer2_preset, st1, st2, mt1, mt2, irq_rst,
        output ft1, ft2, irq, status
    );
endinterface

// File: rtl/opl3_timers.sv
// OPL3 Timer 1 / Timer 2 with overflow flags and IRQ; Timer 2 runs off a
// prescaled copy of the 80 us tick.
module opl3_timers #(
    parameter int TIMER2_DIV = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic         clk,
    input  logic         reset,
    opl3_timers_if.slave bus
);
    localparam int PW = (TIMER2_DIV > 1) ? $clog2(TIMER2_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TIMER2_DIV - 1);

    logic [PW-1:0]                 prescaler_reg;
    logic                          tick2;
    logic [1:0]                    tick;
    logic [1:0]                    st;
    logic [1:0]                    mt;
    logic [1:0][CNT_WIDTH-1:0]     preset;
    logic                          irq_reg;
    logic                          irq_next;

    // Free-running: start/stop of Timer 2 never realigns the prescaler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_reg <= '0;
        end else if (bus.tick_en) begin
            if (prescaler_reg == PRE_LAST)
                prescaler_reg <= '0;
            else
                prescaler_reg <= prescaler_reg + 1'b1;
        end
    end

    assign tick2  = bus.tick_en && (prescaler_reg == PRE_LAST);
    assign tick   = {tick2, bus.tick_en};
    assign st     = {bus.st2, bus.st1};
    assign mt     = {bus.mt2, bus.mt1};
    assign preset = {bus.timer2_preset, bus.timer1_preset};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_tmr
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic [CNT_WIDTH-1:0] cnt_next;
            logic                 st_q_reg;
            logic                 ft_reg;
            logic                 ft_next;
            logic                 load;
            logic                 ovf;

            always_comb begin
                load     = st[gi] & ~st_q_reg;
                ovf      = 1'b0;
                cnt_next = cnt_reg;
                // A start edge swallows any coincident tick.
                if (load) begin
                    cnt_next = preset[gi];
                end else if (st[gi] && tick[gi]) begin
                    if (&cnt_reg) begin
                        cnt_next = preset[gi];
                        ovf      = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end

                // Set beats irq_rst so an overflow is never lost.
                ft_next = ft_reg;
                if (mt[gi])
                    ft_next = 1'b0;
                else if (ovf)
                    ft_next = 1'b1;
                else if (bus.irq_rst)
                    ft_next = 1'b0;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg  <= '0;
                    st_q_reg <= 1'b0;
                    ft_reg   <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    st_q_reg <= st[gi];
                    ft_reg   <= ft_next;
                end
            end
        end
    endgenerate

    assign irq_next = g_tmr[0].ft_next | g_tmr[1].ft_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            irq_reg <= 1'b0;
        else
            irq_reg <= irq_next;
    end

    assign bus.ft1    = g_tmr[0].ft_reg;
    assign bus.ft2    = g_tmr[1].ft_reg;
    assign bus.irq    = irq_reg;
    assign bus.status = {irq_reg, g_tmr[0].ft_reg, g_tmr[1].ft_reg, 5'b0};
endmodule

// File: tb/tb_opl3_timers.sv
// Directed bench for opl3_timers with hand-computed expectations.
module tb_opl3_timers;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    opl3_timers_if #(.CNT_WIDTH(8)) bus ();

    opl3_timers #(
        .TIMER2_DIV(4),
        .CNT_WIDTH (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance n rising edges, landing 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        bus.tick_en = 1'b1;
        step(1);
        bus.tick_en = 1'b0;
        step(2);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic pulse_irq_rst();
        bus.irq_rst = 1'b1;
        step(1);
        bus.irq_rst = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.tick_en       = 1'b0;
        bus.timer1_preset = 8'h00;
        bus.timer2_preset = 8'h00;
        bus.st1 = 1'b0;
        bus.st2 = 1'b0;
        bus.mt1 = 1'b0;
        bus.mt2 = 1'b0;
        bus.irq_rst = 1'b0;
        step(2);
        check("rst_status", bus.status, 8'h00);
        check("rst_irq", bus.irq, 1'b0);
        check("rst_cnt1", dut.g_tmr[0].cnt_reg, 8'h00);
        check("rst_cnt2", dut.g_tmr[1].cnt_reg, 8'h00);
        reset = 1'b0;
        step(1);

        // Timer 1 preset 0xFE: overflow on the second tick.
        bus.timer1_preset = 8'hFE;
        bus.st1 = 1'b1;
        step(1);
        check("t1_load", dut.g_tmr[0].cnt_reg, 8'hFE);
        do_tick();
        check("t1_tick1_cnt", dut.g_tmr[0].cnt_reg, 8'hFF);
        check("t1_tick1_ft1", bus.ft1, 1'b0);
        do_tick();
        check("t1_tick2_cnt", dut.g_tmr[0].cnt_reg, 8'hFE);
        check("t1_tick2_ft1", bus.ft1, 1'b1);
        check("t1_tick2_irq", bus.irq, 1'b1);
        check("t1_tick2_status", bus.status, 8'hC0);
        pulse_irq_rst();
        check("irqrst_ft1", bus.ft1, 1'b0);
        check("irqrst_irq", bus.irq, 1'b0);

        // Overflow coincident with irq_rst: the set must win.
        do_tick();
        check("coin_pre_cnt", dut.g_tmr[0].cnt_reg, 8'hFF);
        bus.tick_en = 1'b1;
        bus.irq_rst = 1'b1;
        step(1);
        bus.tick_en = 1'b0;
        bus.irq_rst = 1'b0;
        check("coin_ft1", bus.ft1, 1'b1);
        check("coin_irq", bus.irq, 1'b1);
        bus.mt1 = 1'b1;
        step(1);
        check("mask_clr_ft1", bus.ft1, 1'b0);
        check("mask_clr_irq", bus.irq, 1'b0);
        bus.mt1 = 1'b0;
        step(1);

        // Start/stop behaviour.
        bus.st1 = 1'b0;
        step(1);
        bus.timer1_preset = 8'h10;
        bus.st1 = 1'b1;
        step(1);
        check("ss_load", dut.g_tmr[0].cnt_reg, 8'h10);
        ticks(5);
        check("ss_run5", dut.g_tmr[0].cnt_reg, 8'h15);
        bus.st1 = 1'b0;
        step(1);
        ticks(10);
        check("ss_stopped", dut.g_tmr[0].cnt_reg, 8'h15);
        bus.st1 = 1'b1;
        bus.tick_en = 1'b1;
        step(1);
        bus.tick_en = 1'b0;
        check("ss_load_over_tick", dut.g_tmr[0].cnt_reg, 8'h10);
        do_tick();
        check("ss_resume", dut.g_tmr[0].cnt_reg, 8'h11);

        // Reset mid-run with cnt1=0x80 and ft1=1.
        bus.st1 = 1'b0;
        step(1);
        bus.timer1_preset = 8'hFF;
        bus.st1 = 1'b1;
        step(1);
        bus.timer1_preset = 8'h80;
        do_tick();
        check("mid_cnt1", dut.g_tmr[0].cnt_reg, 8'h80);
        check("mid_ft1", bus.ft1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_cnt1", dut.g_tmr[0].cnt_reg, 8'h00);
        check("async_ft1", bus.ft1, 1'b0);
        check("async_irq", bus.irq, 1'b0);
        check("async_status", bus.status, 8'h00);
        bus.st1 = 1'b0;
        step(1);
        reset = 1'b0;
        step(1);

        // Timer 2 with preset 0xFF: prescaler is 0 after reset.
        bus.timer2_preset = 8'hFF;
        bus.st2 = 1'b1;
        step(1);
        check("t2_load", dut.g_tmr[1].cnt_reg, 8'hFF);
        ticks(3);
        check("t2_tick3_ft2", bus.ft2, 1'b0);
        do_tick();
        check("t2_tick4_ft2", bus.ft2, 1'b1);
        check("t2_tick4_status", bus.status, 8'hA0);
        check("t2_tick4_cnt", dut.g_tmr[1].cnt_reg, 8'hFF);
        bus.mt2 = 1'b1;
        step(1);
        check("t2_mask_clr", bus.ft2, 1'b0);
        ticks(8);
        check("t2_masked_ft2", bus.ft2, 1'b0);
        check("t2_masked_irq", bus.irq, 1'b0);
        check("t2_masked_cnt", dut.g_tmr[1].cnt_reg, 8'hFF);
        bus.mt2 = 1'b0;
        step(1);

        // Both timers overflow on the 4th tick (prescaler back at 0).
        bus.timer1_preset = 8'hFC;
        bus.st1 = 1'b1;
        step(1);
        check("both_load1", dut.g_tmr[0].cnt_reg, 8'hFC);
        ticks(3);
        check("both_tick3_status", bus.status, 8'h00);
        do_tick();
        check("both_status", bus.status, 8'hE0);
        pulse_irq_rst();
        check("both_clr_status", bus.status, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
